boron_xor_layer_pipe: RTL and testbench

- Parametrised, pipelined successor to the Boron XOR diffusion layer.
- Mixes a block of four WORD_W-bit words, either forward (encrypt) or inverse (decrypt), selected per transaction.
- Data moves through PIPE_DEPTH register stages under valid/ready flow control, with a user tag carried alongside.
- Sits between the S-box layer and the rotation/key-add stages of the round datapath, for both cipher directions.

---
 rtl/boron_xor_layer_pipe.sv | 129 ++++++++++++
 tb/tb_boron_xor_layer_pipe.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boron_xor_layer_pipe.sv
// Pipelined forward/inverse Boron XOR diffusion layer with valid/ready flow control and tag sideband.
// Define BORON_XOR_STATS_EN to add the blk_count delivered-block counter.
module boron_xor_layer_pipe #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*WORD_W-1:0]   in_data,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*WORD_W-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag
`ifdef BORON_XOR_STATS_EN
    ,
    output logic [31:0]           blk_count
`endif
);

    localparam int unsigned BlkW = 4 * WORD_W;

    function automatic logic [BlkW-1:0] mix(input logic inv, input logic [BlkW-1:0] x);
        logic [WORD_W-1:0] w0, w1, w2, w3;
        logic [WORD_W-1:0] y0, y1, y2, y3;
        w0 = x[WORD_W-1:0];
        w1 = x[2*WORD_W-1:WORD_W];
        w2 = x[3*WORD_W-1:2*WORD_W];
        w3 = x[4*WORD_W-1:3*WORD_W];
        if (!inv) begin
            y0 = w0 ^ w1 ^ w3;
            y1 = w1 ^ w3;
            y2 = w0 ^ w2;
            y3 = w0 ^ w2 ^ w3;
        end else begin
            y0 = w0 ^ w1;
            y1 = w1 ^ w2 ^ w3;
            y2 = w0 ^ w1 ^ w2;
            y3 = w2 ^ w3;
        end
        return {y3, y2, y1, y0};
    endfunction

    logic [PIPE_DEPTH-1:0] v_q, v_d;
    logic [PIPE_DEPTH-1:0] rdy;
    logic [PIPE_DEPTH-1:0] load;
    logic [BlkW-1:0]       data_q [PIPE_DEPTH];
    logic [TAG_W-1:0]      tag_q  [PIPE_DEPTH];
    logic [BlkW-1:0]       mixed;

    assign mixed = mix(in_mode, in_data);

    // A stage can take a beat if it is empty or its successor moves on; bubbles collapse.
    always_comb begin
        rdy = '0;
        rdy[PIPE_DEPTH-1] = !v_q[PIPE_DEPTH-1] | out_ready;
        for (int k = int'(PIPE_DEPTH) - 2; k >= 0; k--) begin
            rdy[k] = !v_q[k] | rdy[k+1];
        end
    end

    always_comb begin
        v_d  = v_q;
        load = '0;
        if (rdy[0]) begin
            v_d[0]  = in_valid;
            load[0] = in_valid;
        end
        for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
            if (rdy[k]) begin
                v_d[k]  = v_q[k-1];
                load[k] = v_q[k-1];
            end
        end
        // flush wins over any transfer in the same cycle, including the input beat
        if (flush) begin
            v_d  = '0;
            load = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            v_q <= v_d;
            if (load[0]) begin
                data_q[0] <= mixed;
                tag_q[0]  <= in_tag;
            end
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                if (load[k]) begin
                    data_q[k] <= data_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[PIPE_DEPTH-1];
    assign out_data  = data_q[PIPE_DEPTH-1];
    assign out_tag   = tag_q[PIPE_DEPTH-1];

`ifdef BORON_XOR_STATS_EN
    logic [31:0] blk_count_q;

    // Not cleared by flush; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q <= '0;
        end else if (out_valid & out_ready) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_boron_xor_layer_pipe.sv
// Self-checking bench for boron_xor_layer_pipe: directed vector table plus hand-written
// backpressure, flush, round-trip and async-reset sequences (stats checks with BORON_XOR_STATS_EN).
module tb_boron_xor_layer_pipe;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned PIPE_DEPTH = 2;
    localparam int unsigned TAG_W      = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_tag;
`ifdef BORON_XOR_STATS_EN
    logic [31:0] blk_count;
`endif

    boron_xor_layer_pipe #(
        .WORD_W    (WORD_W),
        .PIPE_DEPTH(PIPE_DEPTH),
        .TAG_W     (TAG_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
`ifdef BORON_XOR_STATS_EN
        ,
        .blk_count(blk_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    logic [63:0] got_data[$];
    logic [3:0]  got_tag[$];
    int          got_cyc[$];

    always @(posedge clk) cyc++;

    // Handshake signals are registered or settled by the falling edge.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_tag.push_back(out_tag);
            got_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) acc_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_got();
        got_data.delete();
        got_tag.delete();
        got_cyc.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic m, input logic [63:0] d, input logic [3:0] t);
        logic acc;
        int   n;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n, input string name);
        int c;
        c = 0;
        while (got_data.size() < n && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(name, 64'(got_data.size()), 64'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        mode;
        logic [63:0] data;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[8];
    logic [63:0] orig_d[40];
    logic [3:0]  orig_t[40];
    logic [63:0] fwd_d[40];
    logic [3:0]  fwd_t[40];

    initial begin
        vecs[0] = '{1'b0, 64'h0004_0003_0002_0001, 4'h1, 64'h0006_0002_0006_0007};
        vecs[1] = '{1'b1, 64'h0006_0002_0006_0007, 4'h2, 64'h0004_0003_0002_0001};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3, 64'hFFFF_0000_0000_FFFF};
        vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4, 64'h0000_FFFF_FFFF_0000};
        vecs[4] = '{1'b0, 64'h0000_0000_0000_0001, 4'h5, 64'h0001_0001_0000_0001};
        vecs[5] = '{1'b1, 64'h0000_0001_0000_0000, 4'h6, 64'h0001_0001_0001_0000};
        vecs[6] = '{1'b0, 64'h0001_0000_0000_0000, 4'h7, 64'h0001_0000_0001_0001};
        vecs[7] = '{1'b1, 64'h0001_0000_0000_0000, 4'h8, 64'h0001_0000_0001_0000};

        // Reset state while rst_n is held low
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef BORON_XOR_STATS_EN
        check("rst_blk_count", 64'(blk_count), 64'd0);
`endif
        do_reset();

        // Latency of a single beat
        begin
            int lat;
            out_ready = 1'b1;
            send(1'b0, 64'h0004_0003_0002_0001, 4'hA);
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("latency", 64'(lat), 64'(PIPE_DEPTH));
            check("lat_data", out_data, 64'h0006_0002_0006_0007);
            check("lat_tag", 64'(out_tag), 64'hA);
            repeat (3) @(posedge clk);
            #1;
            clear_got();
        end

        // Table vectors back-to-back, modes alternating each beat
        for (int i = 0; i < 8; i++) send(vecs[i].mode, vecs[i].data, vecs[i].tag);
        wait_got(8, "tbl_count");
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            check($sformatf("tbl_data[%0d]", i), got_data[i], vecs[i].exp);
            check($sformatf("tbl_tag[%0d]", i), 64'(got_tag[i]), 64'(vecs[i].tag));
        end
        if (got_cyc.size() == 8) check("tbl_throughput", 64'(got_cyc[7] - got_cyc[0]), 64'd7);
        clear_got();

        // Backpressure: 10 beats, out_ready low for 5 cycles
        begin
            int          acc0;
            logic [63:0] held_d;
            logic [3:0]  held_t;
            out_ready = 1'b0;
            acc0 = acc_cnt;
            fork
                for (int i = 0; i < 10; i++) send(1'b0, 64'(i + 1), 4'(i));
                begin
                    repeat (5) @(posedge clk);
                    #1;
                    check("bp_accepted", 64'(acc_cnt - acc0), 64'(PIPE_DEPTH));
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                    check("bp_out_valid", 64'(out_valid), 64'd1);
                    held_d = out_data;
                    held_t = out_tag;
                    repeat (2) @(posedge clk);
                    #1;
                    check("bp_hold_data", out_data, held_d);
                    check("bp_hold_tag", 64'(out_tag), 64'(held_t));
                    check("bp_first_data", out_data, 64'h0001_0001_0000_0001);
                    out_ready = 1'b1;
                end
            join
            wait_got(10, "bp_count");
            for (int i = 0; i < 10 && i < got_data.size(); i++) begin
                logic [15:0] w;
                w = 16'(i + 1);
                check($sformatf("bp_data[%0d]", i), got_data[i], {w, w, 16'h0000, w});
                check($sformatf("bp_tag[%0d]", i), 64'(got_tag[i]), 64'(i));
            end
            clear_got();
        end

        // flush with a full pipe and a beat presented in the flush cycle
        out_ready = 1'b0;
        for (int i = 0; i < int'(PIPE_DEPTH); i++) send(1'b0, 64'h1234, 4'hC);
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_0000_0001;
        in_tag   = 4'hD;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("flush_dropped", 64'(got_data.size()), 64'd0);
        clear_got();

        // Random round trip: forward then inverse must restore the originals
        for (int i = 0; i < 40; i++) begin
            orig_d[i] = {$urandom(), $urandom()};
            orig_t[i] = 4'($urandom_range(15, 0));
            send(1'b0, orig_d[i], orig_t[i]);
        end
        wait_got(40, "rt_fwd_count");
        for (int i = 0; i < 40; i++) begin
            fwd_d[i] = (i < got_data.size()) ? got_data[i] : 64'd0;
            fwd_t[i] = (i < got_tag.size()) ? got_tag[i] : 4'd0;
        end
        clear_got();
        for (int i = 0; i < 40; i++) send(1'b1, fwd_d[i], fwd_t[i]);
        wait_got(40, "rt_inv_count");
        for (int i = 0; i < 40 && i < got_data.size(); i++) begin
            check($sformatf("rt_data[%0d]", i), got_data[i], orig_d[i]);
            check($sformatf("rt_tag[%0d]", i), 64'(got_tag[i]), 64'(orig_t[i]));
        end
        clear_got();

        // Delivered-block counter and wrap
        do_reset();
        for (int i = 0; i < 7; i++) send(1'b0, 64'(i), 4'(i));
        wait_got(7, "stats_deliver");
        @(posedge clk);
        #1;
`ifdef BORON_XOR_STATS_EN
        check("blk_count_7", 64'(blk_count), 64'd7);
        force dut.blk_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.blk_count_q;
        clear_got();
        send(1'b0, 64'h55, 4'h5);
        wait_got(1, "wrap_deliver");
        @(posedge clk);
        #1;
        check("blk_count_wrap", 64'(blk_count), 64'd0);
`endif
        clear_got();

        // Async reset mid-stream with a full, stalled pipe
        out_ready = 1'b0;
        for (int i = 0; i < int'(PIPE_DEPTH); i++) send(1'b1, 64'hABCD_0000_1111_2222, 4'hE);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
`ifdef BORON_XOR_STATS_EN
        check("mid_rst_blk_count", 64'(blk_count), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_empty", 64'(got_data.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
